// File: rtl/seven_seg_scan_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// seven_seg_pkg
//
// Shared definitions for the seven-segment scan controller:
//   - scanState_t : per-slot scan state (dark gap, then lit digit)
//   - BLANK_CODE  : decoder code that renders every segment off
//   - DP_OFF      : inactive level of the active-low decimal point
//   - SEG_OFF     : all-segments-off pattern
//   - bcdToSegments() : BCD code to {a,b,c,d,e,f,g} segment pattern
// ----------------------------------------------------------------------------
package seven_seg_pkg;

    // BLANK is the dark gap at the start of each digit slot; SHOW is the lit part.
    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scanState_t;

    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam logic       DP_OFF     = 1'b1;
    localparam logic [6:0] SEG_OFF    = 7'b0000000;

    // Segment order is {a,b,c,d,e,f,g}, active-high.
    // Codes 10..15 have no glyph and render fully dark, which is also what
    // makes BLANK_CODE switch a digit off.
    function automatic logic [6:0] bcdToSegments(input logic [3:0] code);
        logic [6:0] segs;
        case (code)
            4'd0:    segs = 7'b1111110;
            4'd1:    segs = 7'b0110000;
            4'd2:    segs = 7'b1101101;
            4'd3:    segs = 7'b1111001;
            4'd4:    segs = 7'b0110011;
            4'd5:    segs = 7'b1011011;
            4'd6:    segs = 7'b1011111;
            4'd7:    segs = 7'b1110000;
            4'd8:    segs = 7'b1111111;
            4'd9:    segs = 7'b1111011;
            default: segs = SEG_OFF;
        endcase
        return segs;
    endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_decoder.sv
// ----------------------------------------------------------------------------
// BCDtoSevenSeg
//
// Purely combinational BCD to seven-segment decoder shared by all digits of
// the scan controller.
//
// Ports:
//   code_i : 4-bit BCD code (10..15 decode to all segments off)
//   seg_o  : segments {a,b,c,d,e,f,g}, active-high
// ----------------------------------------------------------------------------
module BCDtoSevenSeg
    import seven_seg_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    // Single shared lookup; the caller registers code_i so seg_o settles with
    // the anode outputs in the same cycle.
    always_comb begin
        seg_o = bcdToSegments(code_i);
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// seven_seg_scan_ctrl
//
// Time-multiplexed scan controller for an N-digit common-anode seven-segment
// display. One shared decoder is driven with the code of the digit whose anode
// is active. Each digit slot starts with a dark gap (all anodes off) to
// suppress ghosting. New values are captured into a shadow register on a
// one-cycle load strobe and copied to the display register only at a frame
// boundary, so a frame never shows a mix of old and new digits.
//
// Parameters:
//   NUM_DIGITS   : digits scanned (>= 2)
//   SLOT_CYCLES  : clock cycles per digit slot (> BLANK_CYCLES)
//   BLANK_CYCLES : dark cycles at the start of each slot (>= 1)
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   load       : one-cycle strobe capturing bcd_in / dp_in / lzb_en
//   bcd_in     : packed BCD digits, bits [3:0] = digit 0 (least significant)
//   dp_in      : per-digit decimal point, 1 = lit
//   lzb_en     : leading-zero blanking enable
//   ack        : one-cycle pulse when captured data becomes displayed data
//   seg        : segments {a..g}, active-high (decoded from registered code)
//   dp_n       : decimal point, active-low
//   an_n       : anodes, active-low, at most one low
//   frame_done : one-cycle pulse after the last digit's slot
// ----------------------------------------------------------------------------
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 16
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lzb_en,
    output logic                    ack,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_done
);

    localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int DW = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;

    localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOT_CYCLES - 1);
    localparam logic [SW-1:0] BLANK_LAST = SW'(BLANK_CYCLES - 1);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);

    // Scan position
    scanState_t                   state_q, state_d;
    logic [SW-1:0]                slotCnt_q, slotCnt_d;
    logic [DW-1:0]                digitIdx_q, digitIdx_d;
    logic                         frameEnd;

    // Shadow (written by load) and display (applied at frame boundary)
    logic [NUM_DIGITS-1:0][3:0]   shadowBcd_q;
    logic [NUM_DIGITS-1:0]        shadowDp_q;
    logic                         shadowLzb_q;
    logic                         pending_q;
    logic [NUM_DIGITS-1:0][3:0]   dispBcd_q;
    logic [NUM_DIGITS-1:0]        dispDp_q;
    logic                         dispLzb_q;

    // Registered outputs and decoder code
    logic [3:0]                   code_q;
    logic [NUM_DIGITS-1:0]        anN_q;
    logic                         dpN_q;
    logic                         ack_q;
    logic                         frameDone_q;

    // Values presented while the current digit is lit
    logic [NUM_DIGITS-1:0]        blankMask;
    logic                         zeroSoFar;
    logic [3:0]                   showCode;
    logic [NUM_DIGITS-1:0]        showAnN;
    logic                         showDpN;

    // Next scan position. The slot counter runs continuously through both
    // phases of a slot; the dark phase covers counts 0..BLANK_CYCLES-1 and the
    // lit phase the rest. Leaving the last digit's slot is the frame boundary.
    always_comb begin
        state_d    = state_q;
        slotCnt_d  = slotCnt_q + 1'b1;
        digitIdx_d = digitIdx_q;
        frameEnd   = 1'b0;
        case (state_q)
            BLANK: begin
                if (slotCnt_q == BLANK_LAST) begin
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (slotCnt_q == SLOT_LAST) begin
                    state_d   = BLANK;
                    slotCnt_d = '0;
                    if (digitIdx_q == DIGIT_LAST) begin
                        digitIdx_d = '0;
                        frameEnd   = 1'b1;
                    end else begin
                        digitIdx_d = digitIdx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d   = BLANK;
                slotCnt_d = '0;
            end
        endcase
    end

    // Leading-zero blanking: walk from the most significant digit down and
    // keep blanking while everything seen so far is zero. Codes 10..15 are
    // nonzero here, so they stop the blanking even though they render dark.
    // Digit 0 always shows so an all-zero value still displays "0".
    always_comb begin
        zeroSoFar = 1'b1;
        blankMask = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zeroSoFar    = zeroSoFar & (dispBcd_q[i] == 4'd0);
            blankMask[i] = dispLzb_q & zeroSoFar & (i != 0);
        end
    end

    // Lit-phase outputs for the current digit. Whenever the next state is
    // SHOW the digit index and display register are unchanged on that edge
    // (both only move when entering BLANK), so current values are the right
    // ones to register.
    always_comb begin
        showAnN             = '1;
        showAnN[digitIdx_q] = 1'b0;
        showCode            = blankMask[digitIdx_q] ? BLANK_CODE : dispBcd_q[digitIdx_q];
        showDpN             = ~dispDp_q[digitIdx_q];
    end

    // Scan FSM with registered outputs and the load/apply handshake.
    // A load on the boundary cycle still lets the older shadow apply (the
    // copy uses pre-edge shadow), while the later load assignment keeps the
    // pending flag set so the new value goes out one frame later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BLANK;
            slotCnt_q   <= '0;
            digitIdx_q  <= '0;
            shadowBcd_q <= '0;
            shadowDp_q  <= '0;
            shadowLzb_q <= 1'b0;
            pending_q   <= 1'b0;
            dispBcd_q   <= '0;
            dispDp_q    <= '0;
            dispLzb_q   <= 1'b0;
            code_q      <= BLANK_CODE;
            anN_q       <= '1;
            dpN_q       <= DP_OFF;
            ack_q       <= 1'b0;
            frameDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            slotCnt_q   <= slotCnt_d;
            digitIdx_q  <= digitIdx_d;
            ack_q       <= 1'b0;
            frameDone_q <= frameEnd;

            if (frameEnd && pending_q) begin
                dispBcd_q <= shadowBcd_q;
                dispDp_q  <= shadowDp_q;
                dispLzb_q <= shadowLzb_q;
                pending_q <= 1'b0;
                ack_q     <= 1'b1;
            end

            if (load) begin
                shadowBcd_q <= bcd_in;
                shadowDp_q  <= dp_in;
                shadowLzb_q <= lzb_en;
                pending_q   <= 1'b1;
            end

            if (state_d == SHOW) begin
                code_q <= showCode;
                anN_q  <= showAnN;
                dpN_q  <= showDpN;
            end else begin
                code_q <= BLANK_CODE;
                anN_q  <= '1;
                dpN_q  <= DP_OFF;
            end
        end
    end

    // Shared decoder on the registered code keeps seg aligned with an_n.
    BCDtoSevenSeg u_decoder (
        .code_i (code_q),
        .seg_o  (seg)
    );

    assign an_n       = anN_q;
    assign dp_n       = dpN_q;
    assign ack        = ack_q;
    assign frame_done = frameDone_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seven_seg_scan_ctrl
//
// Directed bench for seven_seg_scan_ctrl with NUM_DIGITS=4, SLOT_CYCLES=8,
// BLANK_CYCLES=2. Loads are queued as expected displays with the frame in
// which they should appear; every cycle of every frame is compared against
// the display popped from that queue.
// ----------------------------------------------------------------------------
module tb_seven_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int SC    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * SC;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        load   = 1'b0;
    logic [15:0] bcd_in = '0;
    logic [3:0]  dp_in  = '0;
    logic        lzb_en = 1'b0;
    logic        ack;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_done;

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  dp;
        logic        lzb;
        int          applyFrame;
    } disp_t;

    typedef struct {
        int          k;
        logic [15:0] bcd;
        logic [3:0]  dp;
        logic        lzb;
    } plan_t;

    disp_t sb[$];
    plan_t plan[$];
    disp_t shown;
    int    fr;
    int    total = 0;
    int    bad   = 0;

    localparam logic [13:0] RESET_VEC = {4'b1111, 7'b0000000, 1'b1, 1'b0, 1'b0};

    seven_seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .SLOT_CYCLES  (SC),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .lzb_en     (lzb_en),
        .ack        (ack),
        .seg        (seg),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    function automatic logic [6:0] segOf(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic bit isBlanked(input disp_t d, input int idx);
        logic [15:0] b;
        b = d.bcd;
        if (!d.lzb || idx == 0) return 1'b0;
        for (int j = idx; j < ND; j++) begin
            if (b[4*j +: 4] != 4'd0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Expected {an_n, seg, dp_n, ack, frame_done} at cycle k of a frame.
    function automatic logic [13:0] expectedAt(input int k, input bit fdExp, input bit ackExp);
        int          slot;
        int          dig;
        logic [3:0]  an;
        logic [6:0]  s;
        logic        dpn;
        logic [15:0] b;
        logic [3:0]  dpv;
        slot = k % SC;
        dig  = k / SC;
        b    = shown.bcd;
        dpv  = shown.dp;
        if (slot < BC) begin
            an  = 4'b1111;
            s   = 7'b0000000;
            dpn = 1'b1;
        end else begin
            an  = ~(4'b0001 << dig);
            s   = isBlanked(shown, dig) ? 7'b0000000 : segOf(b[4*dig +: 4]);
            dpn = ~dpv[dig];
        end
        return {an, s, dpn, ackExp && (k == 0), fdExp && (k == 0)};
    endfunction

    task automatic checkOutput(input string tag, input int k, input logic [13:0] obs, input logic [13:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s frame=%0d k=%0d observed=%b required=%b", tag, fr, k, obs, exp);
        end
    endtask

    // Drive a one-cycle load and record the display it should produce.
    // A load sampled on the boundary edge (driven at k=FRAME-1) misses that
    // boundary; a later load aimed at the same frame replaces the earlier one.
    task automatic applyStimulus(input plan_t p, input int k);
        disp_t e;
        load   = 1'b1;
        bcd_in = p.bcd;
        dp_in  = p.dp;
        lzb_en = p.lzb;
        e.bcd  = p.bcd;
        e.dp   = p.dp;
        e.lzb  = p.lzb;
        e.applyFrame = (k == FRAME - 1) ? fr + 2 : fr + 1;
        if (sb.size() > 0 && sb[$].applyFrame == e.applyFrame) begin
            sb[$] = e;
        end else begin
            sb.push_back(e);
        end
    endtask

    // Called at the negedge of cycle 0 of a frame; compares each cycle and
    // returns at cycle 0 of the next frame (or at cycle stopAt if shorter).
    task automatic checkFrame(input int stopAt);
        bit boundary;
        bit ackExp;
        boundary = (fr > 0);
        ackExp   = 1'b0;
        if (boundary && sb.size() > 0 && sb[0].applyFrame == fr) begin
            shown  = sb.pop_front();
            ackExp = 1'b1;
        end
        for (int k = 0; k < stopAt; k++) begin
            checkOutput("scan", k, {an_n, seg, dp_n, ack, frame_done}, expectedAt(k, boundary, ackExp));
            load = 1'b0;
            if (plan.size() > 0 && plan[0].k == k) begin
                applyStimulus(plan.pop_front(), k);
            end
            @(negedge clk);
        end
        if (stopAt == FRAME) fr++;
    endtask

    task automatic clearModel();
        fr = 0;
        sb.delete();
        plan.delete();
        shown = '{bcd: 16'h0000, dp: 4'h0, lzb: 1'b0, applyFrame: 0};
    endtask

    initial begin
        clearModel();

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset", 0, {an_n, seg, dp_n, ack, frame_done}, RESET_VEC);

        // Idle scan of zeros, two frames (second starts with frame_done)
        rst_n = 1'b1;
        checkFrame(FRAME);
        checkFrame(FRAME);

        // Mid-frame load of 1234 appears only after the boundary, with ack
        plan.push_back('{k: 12, bcd: 16'h1234, dp: 4'b0010, lzb: 1'b0});
        checkFrame(FRAME);
        checkFrame(FRAME);

        // Leading-zero blanking of 0050
        plan.push_back('{k: 5, bcd: 16'h0050, dp: 4'b0000, lzb: 1'b1});
        checkFrame(FRAME);
        checkFrame(FRAME);

        // All-zero with blanking: only digit 0 lit, blanked digit 3 keeps its dp
        plan.push_back('{k: 20, bcd: 16'h0000, dp: 4'b1000, lzb: 1'b1});
        checkFrame(FRAME);
        checkFrame(FRAME);

        // Code A counts as nonzero: stops blanking but renders dark
        plan.push_back('{k: 9, bcd: 16'h0A05, dp: 4'b0001, lzb: 1'b1});
        checkFrame(FRAME);
        checkFrame(FRAME);

        // Two loads in one frame: newest wins, single ack
        plan.push_back('{k: 3, bcd: 16'h1111, dp: 4'b0000, lzb: 1'b0});
        plan.push_back('{k: 17, bcd: 16'h2222, dp: 4'b0000, lzb: 1'b0});
        checkFrame(FRAME);
        checkFrame(FRAME);
        checkFrame(FRAME);

        // Load on the boundary cycle: older shadow applies now, new one next frame
        plan.push_back('{k: 10, bcd: 16'h5678, dp: 4'b0100, lzb: 1'b0});
        plan.push_back('{k: FRAME - 1, bcd: 16'h9876, dp: 4'b1001, lzb: 1'b0});
        checkFrame(FRAME);
        checkFrame(FRAME);
        checkFrame(FRAME);
        checkFrame(FRAME);

        // Reset during SHOW of digit 2 with a load still pending
        plan.push_back('{k: 10, bcd: 16'h4321, dp: 4'b1111, lzb: 1'b0});
        checkFrame(2 * SC + 4);
        load  = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 2 * SC + 4, {an_n, seg, dp_n, ack, frame_done}, RESET_VEC);
        @(negedge clk);
        checkOutput("held_reset", 0, {an_n, seg, dp_n, ack, frame_done}, RESET_VEC);
        @(negedge clk);
        clearModel();
        rst_n = 1'b1;
        checkFrame(FRAME);
        checkFrame(FRAME);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
